// File: rtl/odd_parity_checker.sv
// Registered odd-parity checker for a word that already carries its parity bit.
// Flags even-popcount words one cycle after acceptance and keeps error status.
module odd_parity_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic             in_valid,
  input  logic             clr_err,
  output logic             ParityCheck,
  output logic             out_valid,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky
);

  // Handshake: A is consumed on every rising edge where in_valid=1; there is no
  // ready/backpressure. out_valid is high for exactly one cycle per accepted word,
  // and ParityCheck holds its last value while out_valid is low.

  localparam logic [CNT_W-1:0] cntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] cntMax = '1;

  logic wordErr;
  logic incErr;

  // XNOR reduction: 1 when the word has an even number of ones (including zero).
  assign wordErr = ~^A;
  assign incErr  = in_valid & wordErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ParityCheck <= 1'b0;
      out_valid   <= 1'b0;
      err_count   <= '0;
      err_sticky  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ParityCheck <= wordErr;
      end
      // A clear coinciding with a new error leaves that error counted.
      if (clr_err) begin
        err_count  <= incErr ? cntOne : '0;
        err_sticky <= incErr;
      end else if (incErr) begin
        if (err_count != cntMax) begin
          err_count <= err_count + cntOne;
        end
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_odd_parity_checker.sv
// Bench for odd_parity_checker: directed vectors feed an expected queue, and a
// monitor pops one entry per clock and compares both DUT instances (CNT_W=8 and 2).
module tb_odd_parity_checker;

  typedef struct packed {
    logic       pc;
    logic       ov;
    logic [7:0] cnt;
    logic       st;
    logic [1:0] cnt2;
    logic       st2;
  } exp_t;

  localparam int EW = $bits(exp_t);

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       in_valid;
  logic       clr_err;

  logic       pc8, ov8, st8;
  logic [7:0] cnt8;
  logic       pc2, ov2, st2;
  logic [1:0] cnt2;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Bench-side expected state
  logic m_pc = 1'b0;
  int   m_cnt = 0;
  logic m_st = 1'b0;
  int   m_cnt2 = 0;
  logic m_st2 = 1'b0;

  odd_parity_checker #(.WIDTH(4), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .A(a), .in_valid(in_valid), .clr_err(clr_err),
    .ParityCheck(pc8), .out_valid(ov8), .err_count(cnt8), .err_sticky(st8)
  );

  odd_parity_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .A(a), .in_valid(in_valid), .clr_err(clr_err),
    .ParityCheck(pc2), .out_valid(ov2), .err_count(cnt2), .err_sticky(st2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle; exp_err is the hand-computed parity error for a.
  task automatic drive(input logic r, input logic [3:0] av, input logic v,
                       input logic c, input logic exp_err);
    exp_t e;
    logic inc;
    rst = r;
    a = av;
    in_valid = v;
    clr_err = c;
    inc = v & exp_err;
    if (r) begin
      m_pc = 1'b0; m_cnt = 0; m_st = 1'b0; m_cnt2 = 0; m_st2 = 1'b0;
    end else begin
      if (v) m_pc = exp_err;
      if (c) begin
        m_cnt = inc ? 1 : 0;  m_st = inc;
        m_cnt2 = inc ? 1 : 0; m_st2 = inc;
      end else if (inc) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        m_st = 1'b1; m_st2 = 1'b1;
      end
    end
    e.pc = m_pc;
    e.ov = r ? 1'b0 : v;
    e.cnt = 8'(m_cnt);
    e.st = m_st;
    e.cnt2 = 2'(m_cnt2);
    e.st2 = m_st2;
    exp_q.push_back(EW'(e));
    @(negedge clk);
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        chk("parity_check", 8'(pc8), 8'(e.pc));
        chk("out_valid", 8'(ov8), 8'(e.ov));
        chk("err_count", cnt8, e.cnt);
        chk("err_sticky", 8'(st8), 8'(e.st));
        chk("parity_check_w2", 8'(pc2), 8'(e.pc));
        chk("out_valid_w2", 8'(ov2), 8'(e.ov));
        chk("err_count_w2", 8'(cnt2), 8'(e.cnt2));
        chk("err_sticky_w2", 8'(st2), 8'(e.st2));
      end
    end
  end

  // stimulus
  initial begin
    logic [15:0] sweep_err;
    int wait_cycles;
    // parity error for A = 0..F, bit i corresponds to A=i
    sweep_err = 16'b1001_0110_0110_1001;
    rst = 1'b1; a = 4'h0; in_valid = 1'b0; clr_err = 1'b0;
    @(negedge clk);

    // reset with valid traffic present, then one idle cycle
    drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // truth sweep
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 1'b1, 1'b0, sweep_err[i]);
    end

    // hold while idle
    drive(1'b0, 4'h3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h1, 1'b0, 1'b0, 1'b1);

    // clear collision: build count to 5, clear with an error word
    drive(1'b0, 4'h1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 4'h5, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'h7, 1'b1, 1'b1, 1'b0);

    // saturation on the narrow counter, odd words in between
    for (int i = 0; i < 5; i++) drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'h8, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0);

    // reset mid-stream, then counting resumes from 0
    for (int i = 0; i < 3; i++) drive(1'b0, 4'hC, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'hA, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'h6, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
